// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared types and constants for the RV32I front end.
//   fetch_state_e    : fetch FSM states (request, wait for response, output)
//   XLEN / ILEN      : datapath and instruction widths
//   RESET_PC_DEFAULT : first fetch address after reset
//   PC_STEP          : sequential PC increment
package rv32i_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP          = 32'd4;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_target_calc.sv
// pc_target_calc: combinational next-PC adder fed by execute's PC-A/PC-B
// select pair. Purely combinational so trace/checker logic can reuse it.
//   PCAsrc   in  : 1 = addend A is ex_imm, 0 = addend A is 4
//   PCBsrc   in  : 1 = addend B is ex_rs1 (JALR), 0 = addend B is ex_pc
//   ex_pc    in  : PC of the instruction in execute
//   ex_imm   in  : sign-extended immediate
//   ex_rs1   in  : rs1 operand
//   target   out : word-aligned target address
//   misalign out : target had bit 1 set (after JALR bit-0 clear)
module pc_target_calc
  import rv32i_pkg::*;
(
  input  logic            PCAsrc,
  input  logic            PCBsrc,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_rs1,
  output logic [XLEN-1:0] target,
  output logic            misalign
);

  logic [XLEN-1:0] addend_a;
  logic [XLEN-1:0] addend_b;
  logic [XLEN-1:0] raw_sum;
  logic [XLEN-1:0] jalr_sum;

  assign addend_a = PCAsrc ? ex_imm : PC_STEP;
  assign addend_b = PCBsrc ? ex_rs1 : ex_pc;
  assign raw_sum  = addend_a + addend_b;   // wraps modulo 2^32

  // JALR drops bit 0 of the sum before the alignment test.
  assign jalr_sum = raw_sum & ~{{(XLEN-1){1'b0}}, PCBsrc};

  assign misalign = jalr_sum[1];
  assign target   = jalr_sum & ~{{(XLEN-2){1'b0}}, 2'b11};

endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: RV32I fetch stage. Holds the PC, issues one outstanding
// instruction-memory request at a time and presents the fetched word to
// decode through a one-entry output register. Redirects on taken branches
// and jumps resolved in execute.
//   clk, rst_n        : clock, asynchronous active-low reset
//   ex_valid          : execute holds a resolved instruction
//   PCAsrc, PCBsrc    : next-PC adder selects from execute
//   ex_pc/imm/rs1     : adder operands from execute
//   imem_req/addr     : fetch request and word-aligned address (registered)
//   imem_gnt          : request accepted this cycle
//   imem_rvalid/rdata : response valid and instruction word
//   if_valid/pc/instr : instruction presented to decode (registered)
//   if_ready          : decode accepts the presented instruction
//   misalign_err      : one-cycle pulse, redirect target had bit 1 set
module pc_fetch
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic            PCAsrc,
  input  logic            PCBsrc,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_rs1,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [ILEN-1:0] if_instr,
  input  logic            if_ready,
  output logic            misalign_err
);

  fetch_state_e    state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic            kill, kill_n;
  logic            capture;

  logic            redirect;
  logic [XLEN-1:0] target;
  logic            target_misalign;

  pc_target_calc u_target (
    .PCAsrc   (PCAsrc),
    .PCBsrc   (PCBsrc),
    .ex_pc    (ex_pc),
    .ex_imm   (ex_imm),
    .ex_rs1   (ex_rs1),
    .target   (target),
    .misalign (target_misalign)
  );

  // With PCAsrc = 0 the sequential PC already equals ex_pc + 4, so only a
  // PCAsrc select is an actual redirect.
  assign redirect = ex_valid && PCAsrc;

  // NOTE: every signal driven here gets a default first so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    kill_n  = kill;
    capture = 1'b0;

    unique case (state)
      S_REQ: begin
        // The first cycle after reset has imem_req low; a grant then is
        // not for us.
        if (imem_req && imem_gnt) begin
          state_n = S_WAIT;
          kill_n  = redirect;   // response to the old address is stale
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (kill || redirect) begin
            state_n = S_REQ;
            kill_n  = 1'b0;
          end else begin
            capture = 1'b1;
            pc_n    = pc + PC_STEP;   // wraps 0xFFFF_FFFC -> 0
            state_n = S_OUT;
          end
        end else if (redirect) begin
          kill_n = 1'b1;
        end
      end
      S_OUT: begin
        // A same-cycle if_ready transfer still completes; decode flush is
        // handled by pipeline control.
        if (redirect || if_ready) begin
          state_n = S_REQ;
        end
      end
      default: state_n = S_REQ;
    endcase

    if (redirect) begin
      pc_n = target;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_REQ;
      pc           <= RESET_PC;
      kill         <= 1'b0;
      imem_req     <= 1'b0;
      imem_addr    <= RESET_PC;
      if_valid     <= 1'b0;
      if_pc        <= '0;
      if_instr     <= '0;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_n;
      pc           <= pc_n;
      kill         <= kill_n;
      // Outputs are registered from next-state values so they line up
      // with the state they describe.
      imem_req     <= (state_n == S_REQ);
      imem_addr    <= pc_n;
      if_valid     <= (state_n == S_OUT);
      misalign_err <= redirect && target_misalign;
      if (capture) begin
        if_pc    <= pc;
        if_instr <= imem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed self-checking bench for pc_fetch. Inputs are driven
// and outputs sampled on the falling clock edge.
module tb_pc_fetch;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic        PCAsrc;
  logic        PCBsrc;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [31:0] ex_rs1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;
  logic        misalign_err;

  int n_checks = 0;
  int n_errors = 0;

  pc_fetch dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_valid     (ex_valid),
    .PCAsrc       (PCAsrc),
    .PCBsrc       (PCBsrc),
    .ex_pc        (ex_pc),
    .ex_imm       (ex_imm),
    .ex_rs1       (ex_rs1),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_instr     (if_instr),
    .if_ready     (if_ready),
    .misalign_err (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive_ex(input logic a, input logic b, input logic [31:0] pc,
                          input logic [31:0] imm, input logic [31:0] rs1);
    ex_valid = 1'b1;
    PCAsrc   = a;
    PCBsrc   = b;
    ex_pc    = pc;
    ex_imm   = imm;
    ex_rs1   = rs1;
  endtask

  task automatic clear_ex();
    ex_valid = 1'b0;
    PCAsrc   = 1'b0;
    PCBsrc   = 1'b0;
  endtask

  // One zero-wait-state fetch starting in S_REQ: grant, response next
  // cycle, decode accepts. Returns in S_REQ for the following address.
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data);
    check("req", imem_req, 1);
    check("addr", imem_addr, addr);
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    check("wait_req", imem_req, 0);
    check("wait_valid", if_valid, 0);
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    @(negedge clk);
    imem_rvalid = 1'b0;
    check("out_valid", if_valid, 1);
    check("out_pc", if_pc, addr);
    check("out_instr", if_instr, data);
    if_ready = 1'b1;
    @(negedge clk);
    if_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    ex_valid    = 1'b0;
    PCAsrc      = 1'b0;
    PCBsrc      = 1'b0;
    ex_pc       = '0;
    ex_imm      = '0;
    ex_rs1      = '0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if_ready    = 1'b0;

    // Reset held for three cycles.
    repeat (3) @(negedge clk);
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", if_valid, 0);
    check("rst_pc", if_pc, 32'h0);
    check("rst_instr", if_instr, 32'h0);
    check("rst_misalign", misalign_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Sequential run.
    do_fetch(32'h0000_0000, 32'h0000_0013);
    do_fetch(32'h0000_0004, 32'h0010_0093);
    do_fetch(32'h0000_0008, 32'h0020_0113);

    // Branch while waiting on the response for 0xC.
    check("br_addr", imem_addr, 32'h0000_000C);
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    drive_ex(1'b1, 1'b0, 32'h100, 32'h20, 32'h0);
    @(negedge clk);
    clear_ex();
    check("br_wait_valid", if_valid, 0);
    check("br_wait_req", imem_req, 0);
    check("br_misalign", misalign_err, 0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rvalid = 1'b0;
    check("br_drop_valid", if_valid, 0);
    check("br_hold_pc", if_pc, 32'h0000_0008);
    check("br_target", imem_addr, 32'h0000_0120);
    do_fetch(32'h0000_0120, 32'h0000_0033);

    // JALR from S_REQ, aligned target.
    drive_ex(1'b1, 1'b1, 32'h0, 32'h3, 32'h2001);
    @(negedge clk);
    clear_ex();
    check("jalr_addr", imem_addr, 32'h0000_2004);
    check("jalr_req", imem_req, 1);
    check("jalr_noerr", misalign_err, 0);

    // JALR with bit 1 set: aligned down, one-cycle error pulse.
    drive_ex(1'b1, 1'b1, 32'h0, 32'h3, 32'h1003);
    @(negedge clk);
    clear_ex();
    check("jalr_mis_addr", imem_addr, 32'h0000_1004);
    check("jalr_mis_err", misalign_err, 1);
    @(negedge clk);
    check("jalr_mis_pulse", misalign_err, 0);
    do_fetch(32'h0000_1004, 32'h0000_0067);

    // Resolved instruction without PCAsrc: no redirect.
    drive_ex(1'b0, 1'b0, 32'h1004, 32'h40, 32'h0);
    @(negedge clk);
    clear_ex();
    check("noredir_addr", imem_addr, 32'h0000_1008);

    // Redirect in the same cycle as the grant.
    imem_gnt = 1'b1;
    drive_ex(1'b1, 1'b0, 32'h300, 32'h10, 32'h0);
    @(negedge clk);
    imem_gnt = 1'b0;
    clear_ex();
    check("gntredir_req", imem_req, 0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_BAD0;
    @(negedge clk);
    imem_rvalid = 1'b0;
    check("gntredir_valid", if_valid, 0);
    check("gntredir_addr", imem_addr, 32'h0000_0310);

    // Backpressure in S_OUT for five cycles.
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1234_5678;
    @(negedge clk);
    imem_rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", if_valid, 1);
      check("bp_pc", if_pc, 32'h0000_0310);
      check("bp_instr", if_instr, 32'h1234_5678);
      check("bp_req", imem_req, 0);
      @(negedge clk);
    end
    if_ready = 1'b1;
    @(negedge clk);
    if_ready = 1'b0;
    check("bp_next_req", imem_req, 1);
    check("bp_next_addr", imem_addr, 32'h0000_0314);

    // Redirect from S_OUT drops if_valid.
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_0093;
    @(negedge clk);
    imem_rvalid = 1'b0;
    check("outredir_pre", if_valid, 1);
    drive_ex(1'b1, 1'b0, 32'h200, 32'h40, 32'h0);
    @(negedge clk);
    clear_ex();
    check("outredir_valid", if_valid, 0);
    check("outredir_req", imem_req, 1);
    check("outredir_addr", imem_addr, 32'h0000_0240);

    // PC wrap from the top of the address space.
    drive_ex(1'b1, 1'b0, 32'h0, 32'hFFFF_FFFC, 32'h0);
    @(negedge clk);
    clear_ex();
    check("wrap_top", imem_addr, 32'hFFFF_FFFC);
    do_fetch(32'hFFFF_FFFC, 32'h0000_0013);
    check("wrap_addr", imem_addr, 32'h0000_0000);

    // Reset while a response is outstanding; stale response follows.
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("mrst_req", imem_req, 0);
    check("mrst_addr", imem_addr, 32'h0);
    check("mrst_valid", if_valid, 0);
    check("mrst_pc", if_pc, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst_rel_req", imem_req, 1);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hFEED_FACE;
    @(negedge clk);
    imem_rvalid = 1'b0;
    check("mrst_stale_valid", if_valid, 0);
    check("mrst_stale_addr", imem_addr, 32'h0);
    @(negedge clk);
    check("mrst_stale_valid2", if_valid, 0);
    do_fetch(32'h0000_0000, 32'h0000_0113);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Fetch stage of the RV32I core. Holds the program counter, issues instruction-memory requests, and presents fetched instructions to decode. It sits directly downstream of branch-condition resolution: it consumes the PC-A/PC-B select pair from execute and redirects on taken branches and jumps. It allows a single outstanding memory request and uses a one-entry output register.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- ex_valid  in  1  execute holds a resolved instruction this cycle
- PCAsrc  in  1  1 = addend A is ex_imm (redirect); 0 = addend A is 4 (no redirect)
- PCBsrc  in  1  1 = addend B is ex_rs1 (JALR); 0 = addend B is ex_pc
- ex_pc  in  32  PC of the instruction in execute
- ex_imm  in  32  sign-extended immediate
- ex_rs1  in  32  rs1 operand
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address, word-aligned
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response data valid
- imem_rdata  in  32  instruction word
- if_valid  out  1  instruction available to decode
- if_pc  out  32  PC of the presented instruction
- if_instr  out  32  presented instruction
- if_ready  in  1  decode accepts; transfer when if_valid && if_ready
- misalign_err  out  1  one-cycle pulse: the redirect target had bit 1 set

## Operation
- Redirect fires when ex_valid && PCAsrc.
- Target = (PCBsrc ? ex_rs1 : ex_pc) + ex_imm, modulo 2^32.
- When PCBsrc = 1, bit 0 of the target is cleared.
- If target bit 1 is set, the PC loads {target[31:2],2'b00} and misalign_err pulses.
- ex_valid && !PCAsrc: no action. The sequential PC already equals ex_pc+4.
- FSM states and transitions:
  - S_REQ: imem_req=1, imem_addr=pc. On imem_gnt, go to S_WAIT.
  - S_WAIT: wait for imem_rvalid.
    - If kill=0: capture if_instr=imem_rdata and if_pc=pc, set pc=pc+4, go to S_OUT.
    - If kill=1: discard the response, clear kill, go to S_REQ.
  - S_OUT: if_valid=1. On if_ready, go to S_REQ.
- imem_rvalid is sampled only in S_WAIT and ignored in every other state.
- Redirect handling by state (pc takes the target in every case):
  - S_REQ without gnt: imem_addr changes next cycle. The address need not stay stable before grant.
  - S_REQ with gnt in the same cycle: go to S_WAIT with kill=1.
  - S_WAIT: set kill=1. If imem_rvalid arrives in the same cycle, discard it and go straight to S_REQ.
  - S_OUT: go to S_REQ and drop if_valid next cycle. A same-cycle if_ready transfer still completes; flushing decode is pipeline control's job.
- A pc+4 wrap from 0xFFFF_FFFC gives 0x0000_0000.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, if_valid=0, if_pc=0, if_instr=0, misalign_err=0, kill=0, pc=RESET_PC.
- The FSM resets to S_REQ. imem_req asserts on the first edge after rst_n deasserts.
- All outputs are registered. Reset mid-operation clears state immediately, and any stale response is ignored.
- With zero wait states and if_ready=1, throughput is 1 instruction per 3 cycles (REQ→WAIT→OUT).
- Redirect latency:
  - From S_REQ/S_OUT: target on imem_addr one cycle after the redirect.
  - From S_WAIT: target on imem_addr one cycle after the killed response arrives.
- misalign_err asserts the cycle after the redirect, for exactly one cycle.
- Under backpressure (if_ready=0), if_valid, if_pc and if_instr hold stable and imem_req stays 0.

## Structure
- rv32i_pkg holds:
  - the fetch state enum (S_REQ, S_WAIT, S_OUT)
  - the RESET_PC default
  - the instruction-width constant
- One combinational sub-module, pc_target_calc: inputs PCAsrc, PCBsrc, ex_pc, ex_imm, ex_rs1; outputs an aligned target and a misalign flag. It can be reused by trace and checker logic.

## Test plan
- Reset: hold rst_n low for 3 cycles, then release → imem_req=1, imem_addr=0x0 on the first edge; if_valid stays 0 until the first response.
- Sequential run: gnt immediate, rvalid next cycle, if_ready=1 → imem_addr steps 0x0, 0x4, 0x8; if_pc/if_instr match each rdata.
- Branch in S_WAIT: ex_pc=0x100, ex_imm=0x20, PCAsrc=1, PCBsrc=0 → in-flight response dropped (no if_valid), next imem_addr=0x120.
- JALR: PCBsrc=1, ex_rs1=0x2001, ex_imm=0x3 → imem_addr=0x2004, no error. Then ex_rs1=0x1003, ex_imm=0x3 → imem_addr=0x1004, misalign_err pulses once.
- Backpressure: if_ready=0 for 5 cycles in S_OUT → if_* outputs stable, imem_req=0; on if_ready=1, the next request goes out at pc+4.
- Reset mid-S_WAIT, with rvalid arriving 2 cycles after release → the response is ignored, imem_addr=RESET_PC, no if_valid from the stale response.
